// File: rtl/i2c_slave_byte_engine.sv
// rtl/i2c_slave_byte_engine.sv - I2C slave byte engine: address match, ACK, byte write/read
//
// Ports:
//   pclk        system clock, all logic on rising edge
//   areset      synchronous active-low reset
//   slave_addr  own address, sampled when the address byte completes
//   scl_i/sda_i raw asynchronous bus inputs
//   sda_oe      1 = pull SDA low (open drain)
//   rx_data     last byte written by the master; rx_valid one-cycle strobe
//   tx_data     byte returned on a master read; tx_valid says it is available
//   tx_ready    one-cycle strobe when tx_data is consumed
//   read_write  R/W bit of the current transfer (1 = READ)
//   busy        high from START until STOP
module i2c_slave_byte_engine #(
    parameter int SLAVE_ADDRESS_WIDTH = 7,
    parameter int DATA_WIDTH          = 8,
    parameter int MSB_FIRST           = 1
) (
    input  logic                           pclk,
    input  logic                           areset,
    input  logic [SLAVE_ADDRESS_WIDTH-1:0] slave_addr,
    input  logic                           scl_i,
    input  logic                           sda_i,
    output logic                           sda_oe,
    output logic [DATA_WIDTH-1:0]          rx_data,
    output logic                           rx_valid,
    input  logic [DATA_WIDTH-1:0]          tx_data,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    output logic                           read_write,
    output logic                           busy
);
    localparam int AW = SLAVE_ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int SW = (AW + 1 > DW) ? AW + 1 : DW;
    localparam int CW = $clog2(SW + 2);
    localparam logic [CW-1:0] ADDR_LAST = CW'(AW);
    localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   bit_cnt, cnt_n;
    logic [SW-1:0]   shreg, sh_n;
    logic            oe_n, rxv_n, txr_n, rw_n, busy_n;
    logic [DW-1:0]   rxd_n;

    logic scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [SW-1:0]   addr_shift;
    logic            addr_match;
    logic [DW-1:0]   data_in, tx_load, rd_shift;
    logic            tx_first, rd_next;

    always_comb begin
        scl_rise  = scl_s2 & ~scl_h;
        scl_fall  = ~scl_s2 & scl_h;
        start_det = ~sda_s2 & sda_h & scl_s2;
        stop_det  = sda_s2 & ~sda_h & scl_s2;

        // Address is always MSB first with R/W as the final bit.
        addr_shift = {shreg[SW-2:0], sda_s2};
        addr_match = (addr_shift[AW:1] == slave_addr);

        data_in  = (MSB_FIRST != 0) ? {shreg[DW-2:0], sda_s2} : {sda_s2, shreg[DW-1:1]};
        // No data offered: return all ones so the bus simply floats high.
        tx_load  = tx_valid ? tx_data : '1;
        tx_first = (MSB_FIRST != 0) ? tx_load[DW-1] : tx_load[0];
        rd_shift = (MSB_FIRST != 0) ? {shreg[DW-2:0], 1'b1} : {1'b1, shreg[DW-1:1]};
        rd_next  = (MSB_FIRST != 0) ? rd_shift[DW-1] : rd_shift[0];
    end

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        sh_n    = shreg;
        oe_n    = sda_oe;
        rxd_n   = rx_data;
        rxv_n   = 1'b0;
        txr_n   = 1'b0;
        rw_n    = read_write;
        busy_n  = busy;

        // Bus conditions take priority over any data-edge work in the same cycle.
        if (stop_det) begin
            state_n = IDLE;
            cnt_n   = '0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (start_det) begin
            state_n = ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
            busy_n  = 1'b1;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    sh_n = addr_shift;
                    if (bit_cnt == ADDR_LAST) begin
                        cnt_n = '0;
                        if (addr_match) begin
                            state_n = ADDR_ACK;
                            rw_n    = addr_shift[0];
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end else begin
                        cnt_n = bit_cnt + CW'(1);
                    end
                end
                // First SCL fall asserts the ACK, the second one releases it.
                ADDR_ACK, WR_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        oe_n = 1'b1;
                    end else begin
                        oe_n  = 1'b0;
                        cnt_n = '0;
                        if (state == WR_ACK || !read_write) begin
                            state_n = WR_DATA;
                        end else begin
                            state_n         = RD_DATA;
                            txr_n           = 1'b1;
                            sh_n[DW-1:0]    = tx_load;
                            oe_n            = ~tx_first;
                        end
                    end
                end
                WR_DATA: if (scl_rise) begin
                    sh_n[DW-1:0] = data_in;
                    if (bit_cnt == DATA_LAST) begin
                        rxd_n   = data_in;
                        rxv_n   = 1'b1;
                        cnt_n   = '0;
                        state_n = WR_ACK;
                    end else begin
                        cnt_n = bit_cnt + CW'(1);
                    end
                end
                RD_DATA: if (scl_fall) begin
                    if (bit_cnt == DATA_LAST) begin
                        oe_n    = 1'b0;
                        cnt_n   = '0;
                        state_n = RD_ACK;
                    end else begin
                        cnt_n        = bit_cnt + CW'(1);
                        sh_n[DW-1:0] = rd_shift;
                        oe_n         = ~rd_next;
                    end
                end
                // bit_cnt == 1 marks that the master ACKed on the preceding rise.
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s2) state_n = WAIT_STOP;
                        else        cnt_n   = CW'(1);
                    end else if (scl_fall && bit_cnt == CW'(1)) begin
                        state_n      = RD_DATA;
                        cnt_n        = '0;
                        txr_n        = 1'b1;
                        sh_n[DW-1:0] = tx_load;
                        oe_n         = ~tx_first;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!areset) begin
            scl_s1     <= 1'b1;
            scl_s2     <= 1'b1;
            scl_h      <= 1'b1;
            sda_s1     <= 1'b1;
            sda_s2     <= 1'b1;
            sda_h      <= 1'b1;
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            sda_oe     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            tx_ready   <= 1'b0;
            read_write <= 1'b0;
            busy       <= 1'b0;
        end else begin
            scl_s1     <= scl_i;
            scl_s2     <= scl_s1;
            scl_h      <= scl_s2;
            sda_s1     <= sda_i;
            sda_s2     <= sda_s1;
            sda_h      <= sda_s2;
            state      <= state_n;
            bit_cnt    <= cnt_n;
            shreg      <= sh_n;
            sda_oe     <= oe_n;
            rx_data    <= rxd_n;
            rx_valid   <= rxv_n;
            tx_ready   <= txr_n;
            read_write <= rw_n;
            busy       <= busy_n;
        end
    end
endmodule

// File: tb/tb_i2c_slave_byte_engine.sv
// tb/tb_i2c_slave_byte_engine.sv - directed bench for i2c_slave_byte_engine
module tb_i2c_slave_byte_engine;
    localparam int Q = 10;

    logic       pclk = 1'b0;
    logic       areset = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       bus_sda;
    logic [7:0] tx_data_a = 8'h00;
    logic       tx_valid_a = 1'b0;

    logic       sda_oe_a, rx_valid_a, tx_ready_a, rw_a, busy_a;
    logic [7:0] rx_data_a;
    logic       sda_oe_b, rx_valid_b, tx_ready_b, rw_b, busy_b;
    logic [7:0] rx_data_b;

    int n_checks = 0;
    int n_errors = 0;
    int rxa_cnt = 0, txr_cnt = 0, rxb_cnt = 0;
    logic [7:0] rxa_last = 8'h00, rxb_last = 8'h00;

    assign bus_sda = m_sda & ~sda_oe_a & ~sda_oe_b;

    always #5 pclk = ~pclk;

    i2c_slave_byte_engine #(.SLAVE_ADDRESS_WIDTH(7), .DATA_WIDTH(8), .MSB_FIRST(1)) dut_a (
        .pclk(pclk), .areset(areset), .slave_addr(7'h50),
        .scl_i(m_scl), .sda_i(bus_sda), .sda_oe(sda_oe_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .read_write(rw_a), .busy(busy_a)
    );

    i2c_slave_byte_engine #(.SLAVE_ADDRESS_WIDTH(7), .DATA_WIDTH(8), .MSB_FIRST(0)) dut_b (
        .pclk(pclk), .areset(areset), .slave_addr(7'h33),
        .scl_i(m_scl), .sda_i(bus_sda), .sda_oe(sda_oe_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(tx_ready_b),
        .read_write(rw_b), .busy(busy_b)
    );

    always @(negedge pclk) begin
        if (rx_valid_a) begin
            rxa_cnt  = rxa_cnt + 1;
            rxa_last = rx_data_a;
        end
        if (tx_ready_a) txr_cnt = txr_cnt + 1;
        if (rx_valid_b) begin
            rxb_cnt  = rxb_cnt + 1;
            rxb_last = rx_data_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic i2c_start();
        tick(Q/2); m_sda = 1'b1;
        tick(Q/2); m_scl = 1'b1;
        tick(Q);   m_sda = 1'b0;
        tick(Q);   m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(Q/2); m_sda = 1'b0;
        tick(Q/2); m_scl = 1'b1;
        tick(Q);   m_sda = 1'b1;
        tick(Q);
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        tick(Q/2); m_sda = b;
        tick(Q/2); m_scl = 1'b1;
        tick(Q/2); s = bus_sda;
        tick(Q/2); m_scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, input logic next_valid, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, s);
            d = {d[6:0], s};
        end
        tx_valid_a = next_valid;
        bit_xfer(mack, s);
    endtask

    initial begin
        logic       ack, s;
        logic [7:0] d;
        int         base, waited;

        tick(3);
        check("rst_sda_oe", sda_oe_a, 0);
        check("rst_rx_data", rx_data_a, 0);
        check("rst_rx_valid", rx_valid_a, 0);
        check("rst_tx_ready", tx_ready_a, 0);
        check("rst_read_write", rw_a, 0);
        check("rst_busy", busy_a, 0);
        areset = 1'b1;
        tick(5);

        // Write 0x3C to 0x50
        base = rxa_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("wr_addr_ack", ack, 0);
        check("wr_busy", busy_a, 1);
        write_byte(8'h3C, ack); check("wr_data_ack", ack, 0);
        i2c_stop();
        check("wr_rx_count", rxa_cnt - base, 1);
        check("wr_rx_data", rxa_last, 8'h3C);
        check("wr_rw", rw_a, 0);
        check("wr_busy_after_stop", busy_a, 0);

        // Address mismatch
        base = rxa_cnt;
        i2c_start();
        write_byte(8'hA2, ack); check("nm_addr_nack", ack, 1);
        check("nm_busy", busy_a, 1);
        check("nm_sda_oe", sda_oe_a, 0);
        write_byte(8'h11, ack); check("nm_data_nack", ack, 1);
        i2c_stop();
        check("nm_rx_count", rxa_cnt - base, 0);
        check("nm_busy_after_stop", busy_a, 0);

        // Read 0x96 then 0xFF
        base = txr_cnt;
        tx_data_a = 8'h96; tx_valid_a = 1'b1;
        i2c_start();
        write_byte(8'hA1, ack); check("rd_addr_ack", ack, 0);
        check("rd_rw", rw_a, 1);
        read_byte(1'b0, 1'b0, d); check("rd_byte0", d, 8'h96);
        read_byte(1'b1, 1'b0, d); check("rd_byte1", d, 8'hFF);
        i2c_stop();
        check("rd_tx_ready_count", txr_cnt - base, 2);
        check("rd_busy_after_stop", busy_a, 0);
        check("rd_sda_oe_after_stop", sda_oe_a, 0);

        // LSB-first instance: wire sequence 00000001 -> 0x80
        base = rxa_cnt;
        i2c_start();
        write_byte(8'h66, ack); check("lsb_addr_ack", ack, 0);
        write_byte(8'h01, ack); check("lsb_data_ack", ack, 0);
        i2c_stop();
        check("lsb_rx_count", rxb_cnt, 1);
        check("lsb_rx_data", rxb_last, 8'h80);
        check("lsb_other_rx_count", rxa_cnt - base, 0);

        // Repeated START after 4 data bits
        base = rxa_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("rs_addr0_ack", ack, 0);
        bit_xfer(1'b1, s); bit_xfer(1'b0, s); bit_xfer(1'b1, s); bit_xfer(1'b0, s);
        i2c_start();
        check("rs_rw_retained", rw_a, 0);
        check("rs_busy", busy_a, 1);
        tx_data_a = 8'h5A; tx_valid_a = 1'b1;
        write_byte(8'hA1, ack); check("rs_addr1_ack", ack, 0);
        check("rs_rw", rw_a, 1);
        read_byte(1'b1, 1'b0, d); check("rs_read", d, 8'h5A);
        i2c_stop();
        check("rs_rx_count", rxa_cnt - base, 0);

        // Reset during the address ACK
        base = rxa_cnt;
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_xfer(logic'((8'hA0 >> i) & 8'h01), s);
        waited = 0;
        while (sda_oe_a !== 1'b1 && waited < 20) begin
            tick(1);
            waited++;
        end
        check("rst_ack_seen", sda_oe_a, 1);
        @(negedge pclk); areset = 1'b0;
        @(negedge pclk); areset = 1'b1;
        check("rst_mid_sda_oe", sda_oe_a, 0);
        check("rst_mid_busy", busy_a, 0);
        #1;
        bit_xfer(1'b1, s); check("rst_no_ack", s, 1);
        write_byte(8'h55, ack); check("rst_data_nack", ack, 1);
        check("rst_busy_idle", busy_a, 0);
        i2c_stop();
        check("rst_rx_count", rxa_cnt - base, 0);
        i2c_start();
        write_byte(8'hA0, ack); check("rst_fresh_ack", ack, 0);
        write_byte(8'h77, ack); check("rst_fresh_data_ack", ack, 0);
        i2c_stop();
        check("rst_fresh_rx", rxa_last, 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
